// File: rtl/eth_axi_lite_arb.sv
// rtl/eth_axi_lite_arb.sv - round-robin arbiter sharing one AXI4-Lite register port between requesters
module eth_axi_lite_arb #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [DATA_WIDTH-1:0]         req_rdata,
  output logic [1:0]                    req_resp,
  output logic [ADDR_WIDTH-1:0]         M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]         M_AXI_WDATA,
  output logic [3:0]                    M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]         M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]         M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

  state_t                 state, state_d;
  logic [IW-1:0]          ptr, ptr_d;
  logic [IW-1:0]          gnt, gnt_d;
  logic                   wr, wr_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic                   awvalid, awvalid_d;
  logic                   wvalid, wvalid_d;
  logic                   arvalid, arvalid_d;
  logic                   bready, bready_d;
  logic                   rready, rready_d;
  logic [NUM_REQ-1:0]     ready_q, ready_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [1:0]             resp_q, resp_d;

  logic                   sel_found;
  logic [IW-1:0]          sel_idx;
  logic [IW:0]            cand;
  logic                   aw_left, w_left;

  // Round-robin search: first pending requester at or above ptr, wrapping to 0
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!sel_found && req_valid[cand[IW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IW-1:0];
      end
    end
  end

  // Next-state and next-output logic; every AXI/requester output is registered
  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    gnt_d     = gnt;
    wr_d      = wr;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid;
    wvalid_d  = wvalid;
    arvalid_d = arvalid;
    bready_d  = bready;
    rready_d  = rready;
    ready_d   = '0;
    done_d    = '0;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    aw_left   = 1'b0;
    w_left    = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          gnt_d            = sel_idx;
          wr_d             = req_write[sel_idx];
          addr_d           = req_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d          = req_wdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
          ready_d[sel_idx] = 1'b1;
          awvalid_d        = req_write[sel_idx];
          wvalid_d         = req_write[sel_idx];
          arvalid_d        = !req_write[sel_idx];
          state_d          = ADDR;
        end
      end
      ADDR: begin
        if (wr) begin
          // AW and W channels retire independently; move on once neither is pending
          aw_left   = awvalid && !M_AXI_AWREADY;
          w_left    = wvalid && !M_AXI_WREADY;
          awvalid_d = aw_left;
          wvalid_d  = w_left;
          if (!aw_left && !w_left) begin
            bready_d = 1'b1;
            state_d  = RESP;
          end
        end else if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if ((wr && M_AXI_BVALID) || (!wr && M_AXI_RVALID)) begin
          bready_d    = 1'b0;
          rready_d    = 1'b0;
          resp_d      = wr ? M_AXI_BRESP : M_AXI_RRESP;
          rdata_d     = wr ? '0 : M_AXI_RDATA;
          done_d[gnt] = 1'b1;
          ptr_d       = (gnt == IW'(NUM_REQ-1)) ? '0 : gnt + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      wr      <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      arvalid <= 1'b0;
      bready  <= 1'b0;
      rready  <= 1'b0;
      ready_q <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      gnt     <= gnt_d;
      wr      <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      awvalid <= awvalid_d;
      wvalid  <= wvalid_d;
      arvalid <= arvalid_d;
      bready  <= bready_d;
      rready  <= rready_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  assign req_ready     = ready_q;
  assign req_done      = done_q;
  assign req_rdata     = rdata_q;
  assign req_resp      = resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = wvalid;
  assign M_AXI_BREADY  = bready;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid;
  assign M_AXI_RREADY  = rready;

endmodule

// File: tb/tb_eth_axi_lite_arb.sv
// tb/tb_eth_axi_lite_arb.sv - directed self-checking bench for eth_axi_lite_arb
module tb_eth_axi_lite_arb;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [1:0]  req_valid, req_write, req_ready, req_done;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic [31:0] req_rdata;
  logic [1:0]  req_resp;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int n_checks = 0;
  int n_errors = 0;

  always #5 aclk = ~aclk;

  eth_axi_lite_arb #(.NUM_REQ(2), .ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .ACLK(aclk), .ARESETN(aresetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .req_done(req_done), .req_rdata(req_rdata), .req_resp(req_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // Slave model: four word registers, per-channel programmable wait states
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic        r_err = 1'b0, r_force = 1'b0;
  logic [31:0] r_force_val = '0;
  logic [31:0] mem [4] = '{default: '0};
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic        aw_got, w_got, ar_got;
  logic [3:0]  aw_a, ar_a;
  logic [31:0] w_d;

  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid && (w_cnt >= w_dly);
  assign arready = arvalid && (ar_cnt >= ar_dly);
  assign bvalid  = aw_got && w_got && (b_cnt >= b_dly);
  assign rvalid  = ar_got && (r_cnt >= r_dly);
  assign bresp   = 2'b00;
  assign rresp   = r_err ? 2'b10 : 2'b00;
  assign rdata   = !rvalid ? 32'h0 : (r_force ? r_force_val : mem[ar_a[3:2]]);

  // Slave handshake bookkeeping; shares the arbiter's reset
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      aw_a <= '0; ar_a <= '0; w_d <= '0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      b_cnt  <= (aw_got && w_got && !bvalid) ? b_cnt + 1 : 0;
      r_cnt  <= (ar_got && !rvalid) ? r_cnt + 1 : 0;
      if (awvalid && awready) begin aw_got <= 1'b1; aw_a <= awaddr; end
      if (wvalid && wready) begin w_got <= 1'b1; w_d <= wdata; end
      if (arvalid && arready) begin ar_got <= 1'b1; ar_a <= araddr; end
      if (bvalid && bready) begin
        mem[aw_a[3:2]] <= w_d;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (rvalid && rready) ar_got <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full request from requester idx; lat counts cycles from the ready cycle to the done cycle
  task automatic run_req(input int idx, input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic [1:0] rs, output logic [1:0] dv,
                         output int lat);
    int n;
    req_write[idx]            = wr;
    req_addr[idx*4 +: 4]      = addr;
    req_wdata[idx*32 +: 32]   = wd;
    req_valid[idx]            = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!req_ready[idx] && n < 100);
    if (n >= 100) check("ready_timeout", req_ready[idx], 1);
    req_valid[idx] = 1'b0;
    lat = 0;
    do begin @(negedge aclk); lat++; end while (req_done == 2'b00 && lat < 100);
    rd = req_rdata;
    rs = req_resp;
    dv = req_done;
  endtask

  logic [31:0] rd;
  logic [1:0]  rs, dv;
  int          lat, n, done_cnt, done_at;
  logic [14:0] wv, av, br;

  initial begin
    aresetn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge aclk);
    check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    check("rst_req", {req_ready, req_done, req_resp}, 0);
    check("rst_data", {req_rdata, awaddr, wdata[27:0]}, 0);
    aresetn = 1'b1;
    @(negedge aclk);

    // Single write, zero-wait slave
    req_write[0] = 1'b1; req_addr[3:0] = 4'h4; req_wdata[31:0] = 32'hDEADBEEF; req_valid[0] = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!req_ready[0] && n < 20);
    check("w1_ready", req_ready, 2'b01);
    check("w1_aw_w_same_cycle", {awvalid, wvalid, arvalid}, 3'b110);
    check("w1_awaddr", awaddr, 4'h4);
    check("w1_wdata", wdata, 32'hDEADBEEF);
    check("w1_wstrb_prot", {wstrb, awprot}, {4'hF, 3'b000});
    req_valid[0] = 1'b0;
    lat = 0;
    do begin @(negedge aclk); lat++; end while (req_done == 2'b00 && lat < 20);
    // ready cycle, handshake cycle, response cycle, then done
    check("w1_done_latency", lat, 2);
    check("w1_done", req_done, 2'b01);
    check("w1_resp", req_resp, 2'b00);
    check("w1_mem", mem[1], 32'hDEADBEEF);

    // Sequential registers: writes via req0, readback via req1
    for (int i = 0; i < 4; i++) begin
      run_req(0, 1'b1, 4'(i*4), 32'(i+1), rd, rs, dv, lat);
      check("seq_wr_done", dv, 2'b01);
    end
    for (int i = 0; i < 4; i++) begin
      run_req(1, 1'b0, 4'(i*4), 32'h0, rd, rs, dv, lat);
      check("seq_rd_data", rd, 32'(i+1));
      check("seq_rd_resp", rs, 2'b00);
      check("seq_rd_done", dv, 2'b10);
    end

    // Contention: both requesters pending continuously, grants must alternate from 0
    req_write = 2'b00; req_addr = 8'h40; req_valid = 2'b11;
    for (int k = 0; k < 12; k++) begin
      int m;
      m = 0;
      do begin @(negedge aclk); m++; end while (req_ready == 2'b00 && m < 20);
      check("rr_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    req_valid = 2'b00;
    repeat (6) @(negedge aclk);

    // Skewed handshakes: W accepted 3 cycles after AW, B 5 cycles after that
    aw_dly = 0; w_dly = 3; b_dly = 5;
    req_write[0] = 1'b1; req_addr[3:0] = 4'h8; req_wdata[31:0] = 32'hA5A50001; req_valid[0] = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!req_ready[0] && n < 20);
    req_valid[0] = 1'b0;
    done_cnt = 0; done_at = -1;
    for (int c = 0; c < 15; c++) begin
      wv[c] = wvalid; av[c] = awvalid; br[c] = bready;
      if (req_done[0]) begin done_cnt++; done_at = c; end
      @(negedge aclk);
    end
    check("skew_c0", {av[0], wv[0]}, 2'b11);
    check("skew_c1", {av[1], wv[1], br[1]}, 3'b010);
    check("skew_c3", {wv[3], br[3]}, 2'b10);
    check("skew_c4", {wv[4], br[4]}, 2'b01);
    check("skew_c9", br[9], 1'b1);
    check("skew_done_cnt", done_cnt, 1);
    check("skew_done_at", done_at, 10);
    check("skew_mem", mem[2], 32'hA5A50001);
    w_dly = 0; b_dly = 0;

    // Error path: SLVERR read passes through unchanged
    r_err = 1'b1; r_force = 1'b1; r_force_val = 32'h12345678;
    run_req(0, 1'b0, 4'hC, 32'h0, rd, rs, dv, lat);
    check("err_resp", rs, 2'b10);
    check("err_rdata", rd, 32'h12345678);
    check("err_done", dv, 2'b01);
    r_err = 1'b0; r_force = 1'b0;

    // Reset while in RESP: pointer is 1 here, so only a real pointer reset grants req0 first
    r_dly = 1000;
    req_write = 2'b00; req_addr = 8'h00; req_valid = 2'b10;
    n = 0;
    do begin @(negedge aclk); n++; end while (!req_ready[1] && n < 20);
    check("mid_grant", req_ready, 2'b10);
    req_valid = 2'b00;
    repeat (2) @(negedge aclk);
    check("mid_in_resp", rready, 1'b1);
    req_valid = 2'b11;
    #2 aresetn = 1'b0;
    #1;
    check("mid_async_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    check("mid_async_req", {req_ready, req_done, req_resp, req_rdata}, 0);
    done_cnt = 0;
    repeat (3) begin
      @(negedge aclk);
      if (req_done != 2'b00) done_cnt++;
    end
    check("mid_no_done", done_cnt, 0);
    r_dly = 0;
    aresetn = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (req_ready == 2'b00 && n < 20);
    check("post_rst_first", req_ready, 2'b01);
    req_valid[0] = 1'b0;
    n = 0;
    do begin @(negedge aclk); n++; end while (req_ready == 2'b00 && n < 20);
    check("post_rst_second", req_ready, 2'b10);
    req_valid = 2'b00;
    repeat (6) @(negedge aclk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
